// File: rtl/timer_pkg.sv
// Shared types and implementation-select constants for the load_timer primitive.
package timer_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

   localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
   localparam string ARCH_VIRTEX5    = "VIRTEX5";
   localparam string ARCH_VIRTEX6    = "VIRTEX6";

endpackage

// File: rtl/load_timer.sv
// Loadable down-counter with valid/ready load handshake and one-cycle done pulse.
// Define LOAD_TIMER_AUTO_RELOAD_EN for periodic operation from a captured reload value.
module load_timer
   import timer_pkg::*;
#(
   parameter string       ARCHITECTURE = ARCH_BEHAVIORAL,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned STEP         = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [DATA_WIDTH-1:0] load_value,
   input  logic                  cancel,
   output logic [DATA_WIDTH-1:0] count,
   output logic                  busy,
   output logic                  done
);

   if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_behavioral
      localparam logic [DATA_WIDTH-1:0] StepW = DATA_WIDTH'(STEP);

      state_e                state_q, state_d;
      logic [DATA_WIDTH-1:0] count_q, count_d;
      logic                  done_q,  done_d;
      logic                  xfer;

      assign load_ready = (state_q == StIdle) && rst;
      assign xfer       = load_valid && load_ready;

`ifdef LOAD_TIMER_AUTO_RELOAD_EN
      logic [DATA_WIDTH-1:0] reload_q, reload_d;

      always_comb begin
         reload_d = reload_q;
         if (xfer) begin
            reload_d = load_value;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            reload_q <= '0;
         end else begin
            reload_q <= reload_d;
         end
      end
`endif

      always_comb begin
         state_d = state_q;
         count_d = count_q;
         done_d  = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (xfer) begin
                  if (load_value != '0) begin
                     count_d = load_value;
                     state_d = StRun;
                  end else begin
                     count_d = '0;
                     done_d  = 1'b1;
                  end
               end
            end
            StRun: begin
               // cancel wins over a terminal count on the same cycle
               if (cancel) begin
                  count_d = '0;
                  state_d = StIdle;
               end else if (en) begin
                  if (count_q > StepW) begin
                     count_d = count_q - StepW;
                  end else begin
                     done_d = 1'b1;
`ifdef LOAD_TIMER_AUTO_RELOAD_EN
                     count_d = reload_q;
`else
                     count_d = '0;
                     state_d = StIdle;
`endif
                  end
               end
            end
            default: begin
               state_d = StIdle;
               count_d = '0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            state_q <= StIdle;
            count_q <= '0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
         end
      end

      assign count = count_q;
      assign busy  = (state_q == StRun);
      assign done  = done_q;
   end else if (ARCHITECTURE == ARCH_VIRTEX5) begin : g_virtex5
      assign load_ready = 1'b0;
      assign count      = '0;
      assign busy       = 1'b0;
      assign done       = 1'b0;
   end else if (ARCHITECTURE == ARCH_VIRTEX6) begin : g_virtex6
      assign load_ready = 1'b0;
      assign count      = '0;
      assign busy       = 1'b0;
      assign done       = 1'b0;
   end else begin : g_unknown
      assign load_ready = 1'b0;
      assign count      = '0;
      assign busy       = 1'b0;
      assign done       = 1'b0;
   end

endmodule

// File: tb/tb_load_timer.sv
// Bench for load_timer: two instances (STEP=1, STEP=3) against an integer reference model.
module tb_load_timer;

   localparam int unsigned DW    = 8;
   localparam int          STEP0 = 1;
   localparam int          STEP1 = 3;

   logic          clk = 1'b0;
   logic          rst, en, load_valid, cancel;
   logic [DW-1:0] load_value;
   logic [1:0]    ready, busy, done;
   logic [DW-1:0] cnt [2];

   int n_checks = 0;
   int n_fails  = 0;

   int m_cnt  [2];
   int m_rel  [2];
   bit m_run  [2];
   bit m_done [2];

   always #5 clk = ~clk;

   load_timer #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(DW), .STEP(STEP0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load_valid (load_valid),
      .load_ready (ready[0]),
      .load_value (load_value),
      .cancel     (cancel),
      .count      (cnt[0]),
      .busy       (busy[0]),
      .done       (done[0])
   );

   load_timer #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(DW), .STEP(STEP1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load_valid (load_valid),
      .load_ready (ready[1]),
      .load_value (load_value),
      .cancel     (cancel),
      .count      (cnt[1]),
      .busy       (busy[1]),
      .done       (done[1])
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int step_of(input int i);
      return (i == 0) ? STEP0 : STEP1;
   endfunction

   // Behavioural model: remaining count as a plain integer, one update per clock edge.
   task automatic model_update(input int i);
      int n;
      bit rdy;
      rdy = !m_run[i] && rst;
      if (!rst) begin
         m_cnt[i]  = 0;
         m_run[i]  = 0;
         m_done[i] = 0;
         m_rel[i]  = 0;
      end else begin
         m_done[i] = 0;
         if (!m_run[i]) begin
            if (load_valid && rdy) begin
               m_rel[i] = int'(load_value);
               if (load_value == 0) m_done[i] = 1;
               else begin
                  m_cnt[i] = int'(load_value);
                  m_run[i] = 1;
               end
            end
         end else if (cancel) begin
            m_cnt[i] = 0;
            m_run[i] = 0;
         end else if (en) begin
            n = m_cnt[i] - step_of(i);
            if (n > 0) m_cnt[i] = n;
            else begin
               m_done[i] = 1;
`ifdef LOAD_TIMER_AUTO_RELOAD_EN
               m_cnt[i] = m_rel[i];
`else
               m_cnt[i] = 0;
               m_run[i] = 0;
`endif
            end
         end
      end
   endtask

   task automatic drive(input bit r, input bit e, input bit lv, input int val, input bit c);
      rst        = r;
      en         = e;
      load_valid = lv;
      load_value = DW'(val);
      cancel     = c;
   endtask

   task automatic cycle();
      #1;
      for (int i = 0; i < 2; i++)
         check_eq($sformatf("ready%0d", i), int'(ready[i]), int'(!m_run[i] && rst));
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_update(i);
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("count%0d", i), int'(cnt[i]), m_cnt[i]);
         check_eq($sformatf("busy%0d", i), int'(busy[i]), int'(m_run[i]));
         check_eq($sformatf("done%0d", i), int'(done[i]), int'(m_done[i]));
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 0; m_done[i] = 0;
      end
      drive(0, 0, 0, 0, 0);
      cycle();
      cycle();
      check_eq("rst_count", int'(cnt[0]), 0);
      check_eq("rst_ready", int'(ready[0]), 0);
      drive(1, 0, 0, 0, 0);
      cycle();

`ifndef LOAD_TIMER_AUTO_RELOAD_EN
      // Load 5, STEP=1: 5,4,3,2,1 then 0 with done
      drive(1, 1, 1, 5, 0);
      cycle();
      check_eq("t1_load_cnt", int'(cnt[0]), 5);
      check_eq("t1_load_busy", int'(busy[0]), 1);
      drive(1, 1, 0, 0, 0);
      for (int k = 4; k >= 1; k--) begin
         cycle();
         check_eq("t1_cnt", int'(cnt[0]), k);
         check_eq("t1_nodone", int'(done[0]), 0);
      end
      cycle();
      check_eq("t1_term_cnt", int'(cnt[0]), 0);
      check_eq("t1_term_done", int'(done[0]), 1);
      check_eq("t1_term_busy", int'(busy[0]), 0);
      check_eq("t1_term_ready", int'(ready[0]), 1);
      cycle();
      check_eq("t1_done_once", int'(done[0]), 0);

      // Load 0: immediate done, never busy
      drive(1, 1, 1, 0, 0);
      cycle();
      check_eq("t2_done", int'(done[0]), 1);
      check_eq("t2_busy", int'(busy[0]), 0);
      check_eq("t2_cnt", int'(cnt[0]), 0);
      drive(1, 1, 0, 0, 0);
      cycle();
      check_eq("t2_done_once", int'(done[0]), 0);

      // STEP=3, load 7 with en toggling: 7,4,4,1,1,0
      drive(1, 1, 1, 7, 0);
      cycle();
      check_eq("t3_load", int'(cnt[1]), 7);
      for (int k = 0; k < 5; k++) begin
         drive(1, (k % 2) == 0, 0, 0, 0);
         cycle();
         check_eq("t3_cnt", int'(cnt[1]), (k < 2) ? 4 : (k < 4) ? 1 : 0);
         check_eq("t3_done", int'(done[1]), (k == 4) ? 1 : 0);
      end
      drive(1, 0, 0, 0, 1);
      cycle();

      // Load 200, cancel at 150; then cancel on the terminal-count cycle
      drive(1, 1, 1, 200, 0);
      cycle();
      drive(1, 1, 0, 0, 0);
      for (int k = 0; k < 50; k++) cycle();
      check_eq("t4_at150", int'(cnt[0]), 150);
      drive(1, 1, 0, 0, 1);
      cycle();
      check_eq("t4_cancel_cnt", int'(cnt[0]), 0);
      check_eq("t4_cancel_busy", int'(busy[0]), 0);
      check_eq("t4_cancel_done", int'(done[0]), 0);
      drive(1, 1, 1, 3, 0);
      cycle();
      drive(1, 1, 0, 0, 0);
      cycle();
      cycle();
      check_eq("t4_at1", int'(cnt[0]), 1);
      drive(1, 1, 0, 0, 1);
      cycle();
      check_eq("t4_tc_cancel_done", int'(done[0]), 0);
      check_eq("t4_tc_cancel_busy", int'(busy[0]), 0);
      drive(1, 1, 0, 0, 0);
      cycle();
      check_eq("t4_tc_cancel_late", int'(done[0]), 0);

      // Reset mid-run with load_valid held high
      drive(1, 1, 1, 10, 0);
      cycle();
      drive(1, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) cycle();
      check_eq("t5_at6", int'(cnt[0]), 6);
      drive(0, 1, 1, 10, 0);
      cycle();
      check_eq("t5_rst_cnt", int'(cnt[0]), 0);
      check_eq("t5_rst_busy", int'(busy[0]), 0);
      check_eq("t5_rst_done", int'(done[0]), 0);
      cycle();
      check_eq("t5_rst_ready", int'(ready[0]), 0);
      drive(1, 1, 0, 0, 0);
      cycle();
      check_eq("t5_no_xfer", int'(busy[0]), 0);
`else
      // Auto-reload: load 4, done every 4 enabled cycles, stray load ignored
      drive(1, 1, 1, 4, 0);
      cycle();
      check_eq("t6_load", int'(cnt[0]), 4);
      for (int k = 0; k < 12; k++) begin
         drive(1, 1, k == 5, 9, 0);
         cycle();
         check_eq("t6_cnt", int'(cnt[0]), ((k % 4) == 3) ? 4 : 3 - (k % 4));
         check_eq("t6_done", int'(done[0]), ((k % 4) == 3) ? 1 : 0);
         check_eq("t6_busy", int'(busy[0]), 1);
         check_eq("t6_ready", int'(ready[0]), 0);
      end
      drive(1, 1, 0, 0, 1);
      cycle();
      check_eq("t6_cancel_ready", int'(ready[0]), 1);
      check_eq("t6_cancel_busy", int'(busy[0]), 0);
      check_eq("t6_cancel_done", int'(done[0]), 0);
      // Zero load remains single-shot
      drive(1, 1, 1, 0, 0);
      cycle();
      check_eq("t6_zero_done", int'(done[0]), 1);
      check_eq("t6_zero_busy", int'(busy[0]), 0);
`endif

      // Randomized traffic checked against the model
      for (int k = 0; k < 3000; k++) begin
         int v;
         v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 12));
         drive($urandom_range(0, 99) >= 2, $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 3, v, $urandom_range(0, 99) < 3);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/load_timer.md
Name: load_timer

Overview:
Loadable down-counter/period timer; the consuming end of the up-counter primitive. A client hands over a count through a valid/ready load handshake. The block counts it down to zero on enabled cycles and emits a one-cycle done pulse at terminal count. It lives in the primitives library and is used for programmable delays, frame periods and timeout generation.

Parameters:
ARCHITECTURE, "BEHAVIORAL", implementation select: BEHAVIORAL, VIRTEX5, VIRTEX6. Only BEHAVIORAL carries logic; the others are empty placeholders.
DATA_WIDTH, 8, width of load_value and count.
STEP, 1, positive decrement per enabled cycle, 1 <= STEP < 2^DATA_WIDTH.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
en  input  1  count enable; count holds when low
load_valid  input  1  load request
load_ready  output  1  block can accept a load
load_value  input  DATA_WIDTH  count to load, unsigned
cancel  input  1  abort a running count
count  output  DATA_WIDTH  current remaining count, registered
busy  output  1  high while in RUN, registered
done  output  1  terminal-count pulse, registered, one cycle

Behaviour:
- Reset (rst==0 at posedge clk): state=IDLE, count=0, busy=0, done=0. load_ready=0 while rst==0. load_valid is ignored during reset.
- load_ready = (state==IDLE) && rst==1 (combinational).
- Transfer occurs on a cycle where load_valid && load_ready.
- States: IDLE, RUN.
- IDLE, transfer with load_value!=0: next cycle count=load_value, busy=1, state=RUN.
- IDLE, transfer with load_value==0: next cycle done=1, count=0, stay IDLE.
- IDLE, no transfer: count holds 0, done=0.
- RUN, en==1, count>STEP: count<=count-STEP.
- RUN, en==1, count<=STEP: count<=0, busy<=0, done<=1, state<=IDLE. The count saturates at 0 and never wraps.
- RUN, en==0: count holds, done=0.
- cancel==1 in RUN: next cycle count=0, busy=0, state=IDLE, no done pulse. cancel beats a simultaneous terminal count. cancel in IDLE has no effect.
- load_valid in RUN is ignored; load_ready is 0, so there is no transfer.
- done is high exactly one cycle. When high, count==0 and busy==0.
- load_ready rises in the same cycle done rises, so back-to-back loads give a new RUN with no idle gap beyond the done cycle.
- Latency: from the transfer cycle, done asserts after ceil(load_value/STEP) enabled cycles plus 1 register stage.
- Reset mid-RUN: returns immediately to reset values. No done pulse.
- Arithmetic: unsigned, DATA_WIDTH bits. Compare before subtract so underflow is impossible.

Optional Feature:
LOAD_TIMER_AUTO_RELOAD_EN.
- Defined: a reload register captures load_value on each transfer. At terminal count in RUN, count<=reload, busy stays 1, done pulses 1 cycle, and the block stays in RUN. This gives a periodic tick every ceil(reload/STEP) enabled cycles. A zero load still behaves as single-shot. Only cancel or reset exits RUN. load_ready stays 0 throughout.
- Undefined: single-shot as above. No reload register is synthesized.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, RUN), 1-bit encoding.
  - ARCHITECTURE string constants.
- No sub-module. The state register, count datapath and optional reload register fit in one module. The VIRTEX5/VIRTEX6 branches stay empty in the generate case.

Test Plan:
1. DATA_WIDTH=8, STEP=1, en=1, load 5 -> count 5,4,3,2,1 then 0 with done=1 for one cycle; busy falls with done; load_ready=1 that cycle.
2. Load 0 -> done=1 the cycle after transfer, busy never rises, count stays 0.
3. STEP=3, load 7 -> count 7,4,1, then 0 with done (saturates, no wrap to 254); repeat with en toggling 1,0,1,0 -> count holds on en=0 cycles, done after 3 enabled cycles.
4. Load 200, cancel at count 150 -> next cycle count=0, busy=0, no done. Then assert cancel on the same cycle as terminal count (count=1, en=1) -> no done pulse.
5. Load 10, drop rst to 0 at count 6 -> count=0, busy=0, done=0, load_ready=0 during reset. load_valid held high through reset causes no transfer.
6. LOAD_TIMER_AUTO_RELOAD_EN defined, STEP=1, load 4, en=1 -> done every 4 cycles for 3 periods, busy stays 1, load_ready=0. A load_valid pulse mid-run is ignored. cancel -> IDLE, load_ready=1.
